// File: rtl/dot_product_stream_ctrl.sv
// Streams two unsigned-byte vectors, 8 lanes per beat, through an external
// combinational dot-product unit and returns one accumulated sum per command.
module dot_product_stream_ctrl #(
    parameter int MAX_BEATS = 256,
    parameter int LEN_W     = $clog2(MAX_BEATS + 1),
    parameter int ACC_W     = 19 + $clog2(MAX_BEATS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_vec_a,
    input  logic [63:0]      in_vec_b,
    output logic [63:0]      dp_vec_a,
    output logic [63:0]      dp_vec_b,
    input  logic [18:0]      dp_result,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res_data,
    output logic             res_err,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BEATS);
    localparam logic [LEN_W-1:0] ONE_LEN = LEN_W'(1);

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [LEN_W-1:0]   remaining_q, remaining_d;
    logic [63:0]        dp_vec_a_q, dp_vec_a_d;
    logic [63:0]        dp_vec_b_q, dp_vec_b_d;
    logic               s1_valid_q, s1_valid_d;
    logic               res_err_q, res_err_d;

    // The accumulator is sized so the widened per-beat sum can never wrap.
    function automatic logic [ACC_W-1:0] widen(input logic [18:0] v);
        return {{(ACC_W-19){1'b0}}, v};
    endfunction

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        remaining_d = remaining_q;
        dp_vec_a_d  = dp_vec_a_q;
        dp_vec_b_d  = dp_vec_b_q;
        s1_valid_d  = 1'b0;
        res_err_d   = res_err_q;

        // dp_result belongs to the beat captured on the previous edge.
        if (s1_valid_q) begin
            acc_d = acc_q + widen(dp_result);
        end

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    acc_d       = '0;
                    remaining_d = cmd_len;
                    if (cmd_len == '0) begin
                        res_err_d = 1'b0;
                        state_d   = DONE;
                    end else if (cmd_len > MAX_LEN) begin
                        res_err_d = 1'b1;
                        state_d   = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (in_valid) begin
                    dp_vec_a_d  = in_vec_a;
                    dp_vec_b_d  = in_vec_b;
                    s1_valid_d  = 1'b1;
                    remaining_d = remaining_q - ONE_LEN;
                    if (remaining_q == ONE_LEN) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                state_d = DONE;
            end
            DONE: begin
                if (res_ready) begin
                    res_err_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            remaining_q <= '0;
            dp_vec_a_q  <= '0;
            dp_vec_b_q  <= '0;
            s1_valid_q  <= 1'b0;
            res_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            remaining_q <= remaining_d;
            dp_vec_a_q  <= dp_vec_a_d;
            dp_vec_b_q  <= dp_vec_b_d;
            s1_valid_q  <= s1_valid_d;
            res_err_q   <= res_err_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign in_ready  = (state_q == RUN);
    assign res_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign res_data  = acc_q;
    assign res_err   = res_err_q;
    assign dp_vec_a  = dp_vec_a_q;
    assign dp_vec_b  = dp_vec_b_q;

endmodule

// File: tb/tb_dot_product_stream_ctrl.sv
// Directed bench for dot_product_stream_ctrl with a transaction-level model
// and a stand-in for the external 8-lane dot-product datapath.
module tb_dot_product_stream_ctrl;

    localparam int MAX_BEATS = 256;
    localparam int LEN_W     = $clog2(MAX_BEATS + 1);
    localparam int ACC_W     = 19 + $clog2(MAX_BEATS);
    localparam int BUDGET    = 2000;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [LEN_W-1:0] cmd_len = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [63:0]      in_vec_a = '0;
    logic [63:0]      in_vec_b = '0;
    logic [63:0]      dp_vec_a;
    logic [63:0]      dp_vec_b;
    logic [18:0]      dp_result;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [ACC_W-1:0] res_data;
    logic             res_err;
    logic             busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int ref_cyc = 0;

    dot_product_stream_ctrl #(.MAX_BEATS(MAX_BEATS)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_vec_a(in_vec_a), .in_vec_b(in_vec_b),
        .dp_vec_a(dp_vec_a), .dp_vec_b(dp_vec_b), .dp_result(dp_result),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_err(res_err), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int dot8(input logic [63:0] a, input logic [63:0] b);
        int s = 0;
        for (int i = 0; i < 8; i++) s += int'(a[8*i +: 8]) * int'(b[8*i +: 8]);
        return s;
    endfunction

    assign dp_result = 19'(dot8(dp_vec_a, dp_vec_b));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: command -> beats -> result after fixed latency.
    bit      m_busy = 1'b0;
    int      m_left = 0;
    longint  m_sum = 0;
    bit      m_err = 1'b0;
    int      m_res_at = -1;

    always @(negedge clk) begin
        bit e_cmd, e_in, e_res;
        if (!rst_n) begin
            m_busy = 1'b0; m_left = 0; m_sum = 0; m_err = 1'b0; m_res_at = -1;
            chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
            chk("rst_in_ready", 64'(in_ready), 64'd0);
            chk("rst_res_valid", 64'(res_valid), 64'd0);
            chk("rst_res_data", 64'(res_data), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
        end else begin
            e_cmd = !m_busy;
            e_in  = m_busy && (m_left > 0);
            e_res = m_busy && (m_res_at >= 0) && (cyc >= m_res_at);
            chk("m_cmd_ready", 64'(cmd_ready), 64'(e_cmd));
            chk("m_in_ready", 64'(in_ready), 64'(e_in));
            chk("m_res_valid", 64'(res_valid), 64'(e_res));
            chk("m_busy", 64'(busy), 64'(m_busy));
            if (e_res) begin
                chk("m_res_data", 64'(res_data), 64'(m_sum));
                chk("m_res_err", 64'(res_err), 64'(m_err));
            end
            if (e_res && res_ready) begin
                m_busy = 1'b0; m_res_at = -1;
            end else if (e_cmd && cmd_valid) begin
                m_busy = 1'b1; m_sum = 0;
                m_err  = (int'(cmd_len) > MAX_BEATS);
                if (cmd_len == 0 || m_err) begin
                    m_left = 0; m_res_at = cyc + 1;
                end else begin
                    m_left = int'(cmd_len); m_res_at = -1;
                end
            end else if (e_in && in_valid) begin
                m_sum += longint'(dot8(in_vec_a, in_vec_b));
                m_left--;
                if (m_left == 0) m_res_at = cyc + 2;
            end
        end
    end

    task automatic send_cmd(input int len);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_len   = LEN_W'(len);
        forever begin
            @(negedge clk);
            if (cmd_ready === 1'b1) break;
            if (++n >= BUDGET) begin
                chk("cmd_timeout", 64'd1, 64'd0);
                break;
            end
        end
        ref_cyc = cyc;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [63:0] a, input logic [63:0] b, input int gap);
        int n = 0;
        in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        in_vec_a = a;
        in_vec_b = b;
        forever begin
            @(negedge clk);
            if (in_ready === 1'b1) break;
            if (++n >= BUDGET) begin
                chk("beat_timeout", 64'd1, 64'd0);
                break;
            end
        end
        ref_cyc = cyc;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic get_result(input int hold, input longint exp_data, input bit exp_err,
                              input int exp_lat);
        int n = 0;
        logic [ACC_W-1:0] held;
        res_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (res_valid === 1'b1) break;
            if (++n >= BUDGET) begin
                chk("res_timeout", 64'd1, 64'd0);
                break;
            end
        end
        chk("res_latency", 64'(cyc - ref_cyc), 64'(exp_lat));
        chk("res_in_ready", 64'(in_ready), 64'd0);
        held = res_data;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("bp_res_data", 64'(res_data), 64'(held));
            chk("bp_res_valid", 64'(res_valid), 64'd1);
            chk("bp_busy", 64'(busy), 64'd1);
        end
        @(posedge clk); #1;
        res_ready = 1'b1;
        @(negedge clk);
        chk("res_data", 64'(res_data), 64'(exp_data));
        chk("res_err", 64'(res_err), 64'(exp_err));
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("init_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("init_busy", 64'(busy), 64'd0);
        chk("init_res_valid", 64'(res_valid), 64'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // single beat: 8 lanes of 1*2
        send_cmd(1);
        send_beat(64'h0101010101010101, 64'h0202020202020202, 0);
        get_result(0, 16, 1'b0, 2);

        // four back-to-back saturated beats
        send_cmd(4);
        for (int i = 0; i < 4; i++) send_beat({8{8'hFF}}, {8{8'hFF}}, 0);
        @(negedge clk);
        chk("after_last_in_ready", 64'(in_ready), 64'd0);
        get_result(0, 2080800, 1'b0, 2);

        // maximum-length command, no wrap
        send_cmd(256);
        for (int i = 0; i < 256; i++) send_beat({8{8'hFF}}, {8{8'hFF}}, 0);
        get_result(0, 133171200, 1'b0, 2);

        // gaps on in_valid plus 5 cycles of result backpressure
        send_cmd(3);
        send_beat(64'h0706050403020100, 64'h0101010101010101, 2);
        send_beat(64'h0706050403020100, 64'h0101010101010101, 0);
        send_beat(64'h0706050403020100, 64'h0101010101010101, 3);
        get_result(5, 84, 1'b0, 2);

        // zero-length and oversize commands
        send_cmd(0);
        get_result(0, 0, 1'b0, 1);
        send_cmd(257);
        get_result(1, 0, 1'b1, 1);

        // reset in the middle of a command
        send_cmd(4);
        send_beat({8{8'h11}}, {8{8'h22}}, 0);
        send_beat({8{8'h11}}, {8{8'h22}}, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
        chk("mid_rst_res_valid", 64'(res_valid), 64'd0);
        chk("mid_rst_res_data", 64'(res_data), 64'd0);
        chk("mid_rst_res_err", 64'(res_err), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_dp_vec_a", dp_vec_a, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        send_cmd(1);
        send_beat(64'h0101010101010101, 64'h0303030303030303, 0);
        get_result(0, 24, 1'b0, 2);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dot_product_stream_ctrl.md
Name: dot_product_stream_ctrl

Overview:
- Sequencer that computes the dot product of two long unsigned-byte vectors by streaming them, 8 lanes (64 bits) per beat, through the existing combinational 8-lane dot-product datapath (19-bit result per beat).
- Accepts a command giving the beat count, feeds each accepted beat to the datapath through an operand register, and accumulates the per-beat results.
- Returns one widened sum per command over a valid/ready result port.
- Sits between a DMA/stream source and the dot-product unit; the datapath itself is external to this block.

Parameters:
- MAX_BEATS, 256: maximum 64-bit beats per command.
- LEN_W, $clog2(MAX_BEATS+1): width of the beat-count fields.
- ACC_W, 19+$clog2(MAX_BEATS): accumulator and result width; overflow is impossible by construction.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- cmd_valid  input  1  command offered
- cmd_ready  output  1  command accepted when high with cmd_valid
- cmd_len  input  LEN_W  number of beats for this command
- in_valid  input  1  operand beat offered
- in_ready  output  1  beat accepted when high with in_valid
- in_vec_a  input  64  8 unsigned bytes, lane i = bits [8i+7:8i]
- in_vec_b  input  64  8 unsigned bytes, same lane mapping
- dp_vec_a  output  64  registered operand A to the datapath
- dp_vec_b  output  64  registered operand B to the datapath
- dp_result  input  19  combinational datapath result for dp_vec_a/dp_vec_b
- res_valid  output  1  result available
- res_ready  input  1  consumer takes the result
- res_data  output  ACC_W  accumulated sum
- res_err  output  1  command rejected (cmd_len > MAX_BEATS)
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - acc, remaining, dp_vec_a, dp_vec_b, s1_valid, res_err cleared to 0.
  - Outputs: cmd_ready=1, in_ready=0, res_valid=0, res_data=0, busy=0.
  - Reset mid-command discards all partial state; no result is produced.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - cmd_ready=1, in_ready=0.
  - On cmd fire: acc<=0, remaining<=cmd_len.
  - cmd_len==0: go to DONE with res_err=0 (result 0).
  - cmd_len>MAX_BEATS: go to DONE with res_err=1 (result 0).
  - Otherwise: go to RUN.
- RUN:
  - cmd_ready=0, in_ready=1.
  - On in fire: dp_vec_a<=in_vec_a, dp_vec_b<=in_vec_b, s1_valid<=1, remaining<=remaining-1.
  - With no in fire: s1_valid<=0 and dp_vec_* hold their values.
  - Every cycle with s1_valid=1: acc<=acc+zero-extend(dp_result).
  - Accepting the last beat (remaining==1) moves to DRAIN, so in_ready is 0 in the cycle after the last beat.
  - Gaps in in_valid are legal and unbounded.
- DRAIN:
  - in_ready=0.
  - Adds the final dp_result (s1_valid=1), clears s1_valid, goes to DONE.
- DONE:
  - res_valid=1; res_data=acc and res_err are held stable until res_ready.
  - On res fire: go to IDLE and clear res_err.
  - While res_ready=0, all outputs hold.
  - A new command is accepted no earlier than the cycle after res fire.
- Latency:
  - Last beat accepted at edge T gives res_valid=1 after edge T+2.
  - Zero-length or rejected command: res_valid=1 after the edge following cmd fire.
- Throughput: 1 beat/cycle in RUN. Per command, overhead is 3 cycles (DRAIN, DONE, IDLE) plus any result backpressure.
- Arithmetic:
  - All values are unsigned.
  - Maximum sum is MAX_BEATS*8*255*255, i.e. 133171200 at the default, which is below 2^27.
  - The accumulator never wraps for a legal command.
- Inputs are ignored outside their handshake windows: cmd_* outside IDLE, in_* outside RUN.

Test Plan:
- cmd_len=1, in_vec_a=0x0101010101010101, in_vec_b=0x0202020202020202 -> res_data=16, res_err=0, res_valid exactly 2 cycles after the beat is accepted.
- cmd_len=4, all beats 0xFF in every byte of A and B, back-to-back -> res_data=2080800; in_ready high for exactly 4 accepted beats, then low.
- cmd_len=256, all bytes 0xFF -> res_data=133171200, with no wrap.
- cmd_len=3, A bytes=lane index 0..7, B=0x0101010101010101, random in_valid gaps, res_ready held low 5 cycles -> res_data=84; res_data and res_valid stable during backpressure; busy=1 throughout.
- cmd_len=0 -> res_data=0, res_err=0, res_valid the cycle after cmd fire. cmd_len=257 -> res_err=1, res_data=0, and no in_ready pulse.
- cmd_len=4, rst_n pulsed low after 2 beats -> all outputs at reset values immediately. A following cmd_len=1 with 0x01 by 0x03 bytes -> res_data=24, uncontaminated by the aborted command.
